// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: FSM states, Clause 22/45 frame codes and frame field layout.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    TA,
    DATA,
    DONE
  } mdio_state_e;

  localparam logic [1:0] ST_CLAUSE22   = 2'b01;
  localparam logic [1:0] ST_CLAUSE45   = 2'b00;

  localparam logic [1:0] OP_C22_WRITE  = 2'b01;
  localparam logic [1:0] OP_C22_READ   = 2'b10;
  localparam logic [1:0] OP_C45_ADDR   = 2'b00;
  localparam logic [1:0] OP_C45_WRITE  = 2'b01;
  localparam logic [1:0] OP_C45_READ   = 2'b11;
  localparam logic [1:0] OP_C45_RD_INC = 2'b10;

  // MSB position of each field inside the 32-bit frame image
  localparam int ST_MSB    = 31;
  localparam int OP_MSB    = 29;
  localparam int PHYAD_MSB = 27;
  localparam int REGAD_MSB = 22;
  localparam int TA_MSB    = 17;
  localparam int DATA_MSB  = 15;

  localparam int HDR_LEN  = 14;
  localparam int TA_LEN   = 2;
  localparam int DATA_LEN = 16;

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: toggles mdc every CLK_DIV clks while enabled and flags the clk
// before each mdc edge so the bit engine can act on the same edge.
module mdio_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall,
  output logic mdc_pre_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

  logic [CW-1:0] cnt;
  logic          half_end;

  assign half_end = en && (cnt == CNT_LAST);
  assign mdc_rise = half_end && !mdc;
  assign mdc_fall = half_end && mdc;
  // Last clk but one of a bit: with CLK_DIV=1 that is the low half itself
  assign mdc_pre_fall = (CLK_DIV == 1) ? (en && !mdc) : (en && mdc && (cnt == CNT_PRE));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master_param.sv
// MDIO management master: serialises a 32-bit Clause 22/45 frame image behind an
// optional preamble and, for reads, captures the 16-bit turnaround response.
module mdio_master_param
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        mdc,
  output logic        mdio_oe,
  output logic        mdio_out,
  output logic        busy
);

  localparam int CNT_MAX = (PREAMBLE_LEN > DATA_LEN) ? PREAMBLE_LEN : DATA_LEN;
  localparam int BW      = $clog2(CNT_MAX);
  localparam logic [BW-1:0] PRE_LAST  = BW'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
  localparam logic [BW-1:0] HDR_LAST  = BW'(HDR_LEN - 1);
  localparam logic [BW-1:0] TA_LAST   = BW'(TA_LEN - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_LEN - 1);

  mdio_state_e   state;
  logic [31:0]   frame;
  logic          is_read;
  logic [BW-1:0] bit_cnt;
  logic [15:0]   rx_sr;
  logic [15:0]   rx_nxt;
  logic          mdc_rise;
  logic          mdc_fall;
  logic          mdc_pre_fall;

  mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk          (clk),
    .reset        (reset),
    .en           (busy),
    .mdc          (mdc),
    .mdc_rise     (mdc_rise),
    .mdc_fall     (mdc_fall),
    .mdc_pre_fall (mdc_pre_fall)
  );

  // With CLK_DIV=1 the last sample lands on the same edge that loads rd_data,
  // so rd_data is taken from the post-sample value.
  always_comb begin
    rx_nxt = rx_sr;
    if (state == DATA && is_read && mdc_rise) rx_nxt = {rx_sr[14:0], mdio_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      frame    <= '0;
      is_read  <= 1'b0;
      bit_cnt  <= '0;
      rx_sr    <= '0;
      rd_data  <= '0;
      data_rdy <= 1'b0;
      mdio_oe  <= 1'b0;
      mdio_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      data_rdy <= 1'b0;
      rx_sr    <= rx_nxt;
      case (state)
        IDLE: if (mdio_start) begin
          is_read <= t_data[OP_MSB];
          busy    <= 1'b1;
          mdio_oe <= 1'b1;
          bit_cnt <= '0;
          rx_sr   <= '0;
          if (PREAMBLE_LEN == 0) begin
            state    <= HEADER;
            mdio_out <= t_data[31];
            frame    <= {t_data[30:0], 1'b0};
          end else begin
            state    <= PREAMBLE;
            mdio_out <= 1'b1;
            frame    <= t_data;
          end
        end
        PREAMBLE: if (mdc_fall) begin
          if (bit_cnt == PRE_LAST) begin
            state    <= HEADER;
            bit_cnt  <= '0;
            mdio_out <= frame[31];
            frame    <= {frame[30:0], 1'b0};
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        HEADER: if (mdc_fall) begin
          frame <= {frame[30:0], 1'b0};
          if (bit_cnt == HDR_LAST) begin
            state    <= TA;
            bit_cnt  <= '0;
            mdio_oe  <= !is_read;
            mdio_out <= !is_read && frame[31];
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            mdio_out <= frame[31];
          end
        end
        TA: if (mdc_fall) begin
          frame    <= {frame[30:0], 1'b0};
          mdio_out <= !is_read && frame[31];
          if (bit_cnt == TA_LAST) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // DONE occupies the final clk of the last data bit
        DATA: if (mdc_pre_fall && bit_cnt == DATA_LAST) begin
          state <= DONE;
          if (is_read) begin
            rd_data  <= rx_nxt;
            data_rdy <= 1'b1;
          end
        end else if (mdc_fall) begin
          frame    <= {frame[30:0], 1'b0};
          mdio_out <= !is_read && frame[31];
          bit_cnt  <= bit_cnt + 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mdio_oe  <= 1'b0;
          mdio_out <= 1'b0;
          bit_cnt  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master_param.sv
// Bench for mdio_master_param: three parameterisations driven cycle by cycle against
// a bit-stream model built from frame arithmetic (bit = t / (2*div)).
module tb_mdio_master_param;
  import mdio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  start_v = '0;
  logic [31:0] t_data = '0;
  logic        mdio_in = 1'b0;
  logic [2:0]  mdc_v, oe_v, out_v, busy_v, rdy_v;
  logic [15:0] rd_v [3];

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_rd [3];

  always #5 clk = ~clk;

  mdio_master_param u_a (
    .clk(clk), .reset(reset), .mdio_start(start_v[0]), .t_data(t_data), .mdio_in(mdio_in),
    .rd_data(rd_v[0]), .data_rdy(rdy_v[0]), .mdc(mdc_v[0]), .mdio_oe(oe_v[0]),
    .mdio_out(out_v[0]), .busy(busy_v[0])
  );

  mdio_master_param #(.CLK_DIV(1), .PREAMBLE_LEN(0)) u_b (
    .clk(clk), .reset(reset), .mdio_start(start_v[1]), .t_data(t_data), .mdio_in(mdio_in),
    .rd_data(rd_v[1]), .data_rdy(rdy_v[1]), .mdc(mdc_v[1]), .mdio_oe(oe_v[1]),
    .mdio_out(out_v[1]), .busy(busy_v[1])
  );

  mdio_master_param #(.CLK_DIV(3), .PREAMBLE_LEN(5)) u_c (
    .clk(clk), .reset(reset), .mdio_start(start_v[2]), .t_data(t_data), .mdio_in(mdio_in),
    .rd_data(rd_v[2]), .data_rdy(rdy_v[2]), .mdc(mdc_v[2]), .mdio_oe(oe_v[2]),
    .mdio_out(out_v[2]), .busy(busy_v[2])
  );

  function automatic int div_of(input int cfg);
    return (cfg == 0) ? 2 : (cfg == 1) ? 1 : 3;
  endfunction

  function automatic int pre_of(input int cfg);
    return (cfg == 0) ? 32 : (cfg == 1) ? 0 : 5;
  endfunction

  function automatic logic [31:0] rand_frame(input bit rd);
    logic [31:0] f;
    f = $urandom;
    f[31:30] = f[31] ? ST_CLAUSE22 : ST_CLAUSE45;
    f[29] = rd;
    return f;
  endfunction

  // Runs one frame on DUT cfg starting at the current negedge. Every cycle of the
  // frame is compared; abort_at >= 0 applies reset in that cycle instead of finishing.
  task automatic drive_frame(input int cfg, input logic [31:0] td, input logic [15:0] phy,
                             input int inject_at, input int abort_at, input int idle_after);
    int   d = div_of(cfg);
    int   p = pre_of(cfg);
    int   total = (p + 32) * 2 * d;
    bit   rd_op = td[OP_MSB];
    logic e_oe, e_out;
    logic [4:0] e, o;
    t_data = td;
    start_v[cfg] = 1'b1;
    @(negedge clk);
    for (int t = 0; t < total; t++) begin
      int b = t / (2 * d);
      int j = b - p;
      start_v[cfg] = (t == inject_at);
      t_data = (t == inject_at) ? ~td : $urandom;
      if (rd_op && j >= 16) mdio_in = phy[15 - (j - 16)];
      else mdio_in = 1'($urandom);
      if (j < 0) begin
        e_oe = 1'b1; e_out = 1'b1;
      end else if (rd_op && j >= 14) begin
        e_oe = 1'b0; e_out = 1'b0;
      end else begin
        e_oe = 1'b1; e_out = td[31 - j];
      end
      if (rd_op && t == total - 1) exp_rd[cfg] = phy;
      e = {1'b1, ((t % (2 * d)) >= d), e_oe, e_out, (rd_op && t == total - 1)};
      o = {busy_v[cfg], mdc_v[cfg], oe_v[cfg], out_v[cfg], rdy_v[cfg]};
      checks++;
      if (o !== e || rd_v[cfg] !== exp_rd[cfg]) begin
        failures++;
        $display("FAIL frame cfg=%0d cycle=%0d {busy,mdc,oe,out,rdy}/rd_data got=%b/%h exp=%b/%h",
                 cfg, t, o, rd_v[cfg], e, exp_rd[cfg]);
      end
      if (t == abort_at) begin
        #2 reset = 1'b1;
        for (int c = 0; c < 3; c++) exp_rd[c] = 16'h0;
        for (int k = 0; k < 3; k++) begin
          #1;
          o = {busy_v[cfg], mdc_v[cfg], oe_v[cfg], out_v[cfg], rdy_v[cfg]};
          checks++;
          if (o !== 5'b0 || rd_v[cfg] !== 16'h0) begin
            failures++;
            $display("FAIL reset_abort cfg=%0d step=%0d outputs/rd_data got=%b/%h exp=00000/0000",
                     cfg, k, o, rd_v[cfg]);
          end
          @(negedge clk);
        end
        reset = 1'b0;
        start_v = '0;
        return;
      end
      @(negedge clk);
    end
    start_v[cfg] = 1'b0;
    for (int k = 0; k < idle_after; k++) begin
      o = {busy_v[cfg], mdc_v[cfg], oe_v[cfg], out_v[cfg], rdy_v[cfg]};
      checks++;
      if (o !== 5'b0 || rd_v[cfg] !== exp_rd[cfg]) begin
        failures++;
        $display("FAIL idle cfg=%0d cycle=%0d outputs/rd_data got=%b/%h exp=00000/%h",
                 cfg, k, o, rd_v[cfg], exp_rd[cfg]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [4:0] o;
    reset = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      exp_rd[c] = 16'h0;
      o = {busy_v[c], mdc_v[c], oe_v[c], out_v[c], rdy_v[c]};
      checks++;
      if (o !== 5'b0 || rd_v[c] !== 16'h0) begin
        failures++;
        $display("FAIL reset cfg=%0d outputs/rd_data got=%b/%h exp=00000/0000", c, o, rd_v[c]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_write();
    drive_frame(0, 32'h5002_ABCD, 16'h0000, -1, -1, 3);
  endtask

  task automatic test_spec_read();
    drive_frame(0, 32'h6000_0000, 16'hBEEF, -1, -1, 3);
  endtask

  task automatic test_no_preamble();
    drive_frame(1, {ST_CLAUSE22, OP_C22_READ, 12'($urandom), 16'h0}, 16'($urandom), -1, -1, 2);
    drive_frame(1, {ST_CLAUSE45, OP_C45_WRITE, 28'($urandom)}, 16'($urandom), -1, -1, 2);
    drive_frame(1, {ST_CLAUSE45, OP_C45_RD_INC, 28'($urandom)}, 16'($urandom), -1, -1, 2);
  endtask

  task automatic test_ignore_start();
    drive_frame(0, rand_frame(1'b0), 16'h0, 100, -1, 8);
    drive_frame(2, rand_frame(1'b1), 16'($urandom), 37 * 6 - 1, -1, 10);
    drive_frame(1, rand_frame(1'b1), 16'($urandom), 63, -1, 4);
  endtask

  task automatic test_reset_mid_frame();
    drive_frame(0, rand_frame(1'b1), 16'h1234, -1, 40 * 2 * 2, 0);
    drive_frame(0, {ST_CLAUSE45, OP_C45_READ, 28'($urandom)}, 16'h5A3C, -1, -1, 2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      int c = $urandom_range(0, 2);
      drive_frame(c, rand_frame(1'($urandom)), 16'($urandom), -1, -1, 0);
    end
    drive_frame(2, rand_frame(1'b1), 16'($urandom), -1, -1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int c = $urandom_range(0, 2);
      drive_frame(c, rand_frame(1'($urandom)), 16'($urandom), -1, -1, 1 + $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_spec_write();
    test_spec_read();
    test_no_preamble();
    test_ignore_start();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
